// File: rtl/rs_int_age.sv
// rtl/rs_int_age.sv - integer reservation station: CDB wakeup, age-matrix oldest-ready issue
module rs_int_age #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        kill,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [TAG_W-1:0]            disp_dest,
  input  logic                        disp_rdy1,
  input  logic [DATA_W-1:0]           disp_src1,
  input  logic                        disp_rdy2,
  input  logic [DATA_W-1:0]           disp_src2,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [OP_W-1:0]             iss_op,
  output logic [TAG_W-1:0]            iss_dest,
  output logic [DATA_W-1:0]           iss_opr1,
  output logic [DATA_W-1:0]           iss_opr2,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [DEPTH-1:0] D_ONE  = DEPTH'(1);

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_rdy1;
  logic [DEPTH-1:0]  r_rdy2;
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_src1 [DEPTH];
  logic [DATA_W-1:0] r_src2 [DEPTH];
  // r_older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  r_older [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic              w_disp_fire;
  logic              w_iss_fire;
  logic [DEPTH-1:0]  w_free;
  logic [DEPTH-1:0]  w_alloc;
  logic [DEPTH-1:0]  w_elig;
  logic [DEPTH-1:0]  w_blk;
  logic [DEPTH-1:0]  w_sel;
  logic [DATA_W:0]   w_wk1 [DEPTH];
  logic [DATA_W:0]   w_wk2 [DEPTH];
  logic [DATA_W:0]   w_byp1;
  logic [DATA_W:0]   w_byp2;

  // {hit, data}; scanning downward lets the lowest matching bus win
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  t,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int b = NUM_CDB - 1; b >= 0; b--) begin
      if (v[b] && (t[b*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, d[b*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign disp_ready  = (r_count != C_FULL);
  assign count       = r_count;
  assign w_disp_fire = disp_valid && disp_ready;
  assign w_iss_fire  = iss_valid && iss_ready;

  assign w_free  = ~r_busy;
  assign w_alloc = w_free & (~w_free + D_ONE);
  assign w_elig  = r_busy & r_rdy1 & r_rdy2;
  assign iss_valid = |w_elig;

  assign w_byp1 = snoop(disp_src1[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
  assign w_byp2 = snoop(disp_src2[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = snoop(r_src1[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
      w_wk2[i] = snoop(r_src2[i][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    end
  end

  // An eligible entry is selected when no other eligible entry is older
  always_comb begin
    w_blk = '0;
    w_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_elig[j] && r_older[j][i]) begin
          w_blk[i] = 1'b1;
        end
      end
      w_sel[i] = w_elig[i] && !w_blk[i];
    end
  end

  always_comb begin
    iss_op   = '0;
    iss_dest = '0;
    iss_opr1 = '0;
    iss_opr2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        iss_op   = iss_op   | r_op[i];
        iss_dest = iss_dest | r_dest[i];
        iss_opr1 = iss_opr1 | r_src1[i];
        iss_opr2 = iss_opr2 | r_src2[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      r_busy  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_disp_fire && w_alloc[i]) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= disp_op;
          r_dest[i] <= disp_dest;
          r_rdy1[i] <= disp_rdy1 || w_byp1[DATA_W];
          r_rdy2[i] <= disp_rdy2 || w_byp2[DATA_W];
          r_src1[i] <= (!disp_rdy1 && w_byp1[DATA_W]) ? w_byp1[DATA_W-1:0] : disp_src1;
          r_src2[i] <= (!disp_rdy2 && w_byp2[DATA_W]) ? w_byp2[DATA_W-1:0] : disp_src2;
        end else begin
          if (w_iss_fire && w_sel[i]) begin
            r_busy[i] <= 1'b0;
          end
          if (r_busy[i] && !r_rdy1[i] && w_wk1[i][DATA_W]) begin
            r_rdy1[i] <= 1'b1;
            r_src1[i] <= w_wk1[i][DATA_W-1:0];
          end
          if (r_busy[i] && !r_rdy2[i] && w_wk2[i][DATA_W]) begin
            r_rdy2[i] <= 1'b1;
            r_src2[i] <= w_wk2[i][DATA_W-1:0];
          end
        end
      end

      // New entry is youngest: clear its row, mark every other entry older than it
      if (w_disp_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (w_alloc[i]) begin
              r_older[i][j] <= 1'b0;
            end else if (w_alloc[j]) begin
              r_older[i][j] <= 1'b1;
            end
          end
        end
      end

      case ({w_disp_fire, w_iss_fire})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_int_age.sv
// tb/tb_rs_int_age.sv - self-checking bench for rs_int_age with issue scoreboard
module tb_rs_int_age;
  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 3;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 10;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      reset;
  logic                      kill;
  logic                      disp_valid;
  logic                      disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [TAG_W-1:0]          disp_dest;
  logic                      disp_rdy1;
  logic [DATA_W-1:0]         disp_src1;
  logic                      disp_rdy2;
  logic [DATA_W-1:0]         disp_src2;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      iss_valid;
  logic                      iss_ready;
  logic [OP_W-1:0]           iss_op;
  logic [TAG_W-1:0]          iss_dest;
  logic [DATA_W-1:0]         iss_opr1;
  logic [DATA_W-1:0]         iss_opr2;
  logic [CNT_W-1:0]          count;

  rs_int_age #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_rdy1(disp_rdy1), .disp_src1(disp_src1), .disp_rdy2(disp_rdy2), .disp_src2(disp_src2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
    .iss_opr1(iss_opr1), .iss_opr2(iss_opr2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] o1;
    logic [DATA_W-1:0] o2;
  } iss_t;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    int                exp_cnt;
  } vec_t;

  iss_t exp_q[$];
  iss_t mon_e;
  vec_t tbl[8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_iss(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                            input logic [DATA_W-1:0] o1, input logic [DATA_W-1:0] o2);
    iss_t e;
    e.op = op; e.dest = dest; e.o1 = o1; e.o2 = o2;
    exp_q.push_back(e);
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                      input logic r1, input logic [DATA_W-1:0] s1,
                      input logic r2, input logic [DATA_W-1:0] s2);
    disp_valid = 1'b1; disp_op = op; disp_dest = dest;
    disp_rdy1 = r1; disp_src1 = s1; disp_rdy2 = r2; disp_src2 = s2;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic cdb_drive(input int b, input logic v, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid[b] = v;
    cdb_tag[b*TAG_W +: TAG_W] = tag;
    cdb_data[b*DATA_W +: DATA_W] = data;
  endtask

  // Scoreboard: every accepted issue is matched against the next expected record
  always @(negedge clk) begin
    if (!reset && !kill && iss_valid && iss_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_issue: got dest %0h, required no issue", iss_dest);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_op",   64'(iss_op),   64'(mon_e.op));
        chk("sb_dest", 64'(iss_dest), 64'(mon_e.dest));
        chk("sb_opr1", 64'(iss_opr1), 64'(mon_e.o1));
        chk("sb_opr2", 64'(iss_opr2), 64'(mon_e.o2));
      end
    end
  end

  initial begin
    tbl[0] = '{10'h001, 6'd10, 32'h1000_0001, 32'h2000_0001, 1};
    tbl[1] = '{10'h002, 6'd11, 32'h1000_0002, 32'h2000_0002, 2};
    tbl[2] = '{10'h0F3, 6'd12, 32'hFFFF_FFFF, 32'h0000_0000, 3};
    tbl[3] = '{10'h104, 6'd13, 32'h0000_0000, 32'hFFFF_FFFF, 4};
    tbl[4] = '{10'h205, 6'd14, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5};
    tbl[5] = '{10'h306, 6'd15, 32'h1234_5678, 32'h8765_4321, 6};
    tbl[6] = '{10'h3F7, 6'd16, 32'h0BAD_F00D, 32'hCAFE_BABE, 7};
    tbl[7] = '{10'h008, 6'd63, 32'h0000_0008, 32'h0000_0080, 8};

    reset = 1'b1; kill = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    disp_op = '0; disp_dest = '0; disp_rdy1 = 1'b0; disp_src1 = '0; disp_rdy2 = 1'b0; disp_src2 = '0;
    cdb_clear();
    tick(); tick();
    reset = 1'b0;
    chk("rst_count",      64'(count), 0);
    chk("rst_disp_ready", 64'(disp_ready), 1);
    chk("rst_iss_valid",  64'(iss_valid), 0);
    chk("rst_iss_op",     64'(iss_op), 0);
    chk("rst_iss_opr1",   64'(iss_opr1), 0);

    // Fill to DEPTH with ready ops, then a refused ninth dispatch
    for (int i = 0; i < 8; i++) begin
      disp(tbl[i].op, tbl[i].dest, 1'b1, tbl[i].s1, 1'b1, tbl[i].s2);
      expect_iss(tbl[i].op, tbl[i].dest, tbl[i].s1, tbl[i].s2);
      chk("t1_count", 64'(count), 64'(tbl[i].exp_cnt));
    end
    chk("t1_full_disp_ready", 64'(disp_ready), 0);
    disp(10'h3FF, 6'd1, 1'b1, 32'h9, 1'b1, 32'h9);
    chk("t1_ignored_count", 64'(count), 8);
    chk("t1_oldest_op", 64'(iss_op), 64'(tbl[0].op));
    iss_ready = 1'b1;
    begin
      int k = 0;
      while (count != 0 && k < 20) begin
        tick();
        k++;
      end
    end
    chk("t1_drained", 64'(count), 0);
    chk("t1_empty_iss_valid", 64'(iss_valid), 0);

    // Waiting ops woken out of order; no CDB-to-issue path
    disp(10'h020, 6'd20, 1'b0, 32'd5, 1'b1, 32'h200);
    disp(10'h021, 6'd21, 1'b0, 32'd6, 1'b1, 32'h201);
    disp(10'h022, 6'd22, 1'b0, 32'd7, 1'b1, 32'h202);
    disp(10'h023, 6'd23, 1'b0, 32'd8, 1'b1, 32'h203);
    expect_iss(10'h023, 6'd23, 32'h800, 32'h203);
    expect_iss(10'h021, 6'd21, 32'h600, 32'h201);
    expect_iss(10'h020, 6'd20, 32'h500, 32'h200);
    expect_iss(10'h022, 6'd22, 32'h700, 32'h202);
    chk("t2_count", 64'(count), 4);
    chk("t2_waiting", 64'(iss_valid), 0);
    cdb_drive(0, 1'b1, 6'd8, 32'h800);
    #1;
    chk("t2_no_comb_path", 64'(iss_valid), 0);
    tick(); cdb_clear();
    chk("t2_tag8_first", 64'(iss_dest), 23);
    cdb_drive(2, 1'b1, 6'd6, 32'h600);
    tick(); cdb_clear();
    chk("t2_tag6_next", 64'(iss_dest), 21);
    cdb_drive(0, 1'b1, 6'd7, 32'h700);
    cdb_drive(1, 1'b1, 6'd5, 32'h500);
    tick(); cdb_clear();
    chk("t2_older_of_pair", 64'(iss_dest), 20);
    tick();
    chk("t2_last", 64'(iss_dest), 22);
    tick();
    chk("t2_count_end", 64'(count), 0);
    iss_ready = 1'b0;

    // Older entry at index 2 beats younger refill at index 0
    disp(10'h030, 6'd30, 1'b1, 32'hA1, 1'b1, 32'hA2);
    disp(10'h031, 6'd31, 1'b0, 32'h30, 1'b1, 32'hB2);
    disp(10'h032, 6'd32, 1'b0, 32'h21, 1'b1, 32'hC2);
    expect_iss(10'h030, 6'd30, 32'hA1, 32'hA2);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    disp(10'h033, 6'd33, 1'b0, 32'h21, 1'b1, 32'hD2);
    chk("t3_count", 64'(count), 3);
    expect_iss(10'h032, 6'd32, 32'hC21, 32'hC2);
    expect_iss(10'h033, 6'd33, 32'hC21, 32'hD2);
    expect_iss(10'h031, 6'd31, 32'h3030, 32'hB2);
    cdb_drive(1, 1'b1, 6'h21, 32'hC21);
    tick(); cdb_clear();
    chk("t3_idx2_first", 64'(iss_dest), 32);
    tick();
    chk("t3_hold_selection", 64'(iss_dest), 32);
    iss_ready = 1'b1;
    tick();
    chk("t3_idx0_second", 64'(iss_dest), 33);
    cdb_drive(0, 1'b1, 6'h30, 32'h3030);
    tick(); cdb_clear();
    chk("t3_filler", 64'(iss_dest), 31);
    tick();
    chk("t3_count_end", 64'(count), 0);
    iss_ready = 1'b0;

    // Dispatch-time bypass, then simultaneous dispatch and issue
    cdb_drive(1, 1'b1, 6'h0A, 32'hDEADBEEF);
    disp(10'h040, 6'd40, 1'b0, 32'h0A, 1'b1, 32'h1234);
    cdb_clear();
    chk("t4_bypass_valid", 64'(iss_valid), 1);
    chk("t4_bypass_opr1",  64'(iss_opr1), 64'h DEADBEEF);
    chk("t4_count_before", 64'(count), 1);
    expect_iss(10'h040, 6'd40, 32'hDEADBEEF, 32'h1234);
    expect_iss(10'h041, 6'd41, 32'h41, 32'h42);
    iss_ready = 1'b1;
    disp(10'h041, 6'd41, 1'b1, 32'h41, 1'b1, 32'h42);
    chk("t4_count_same", 64'(count), 1);
    tick();
    chk("t4_count_end", 64'(count), 0);
    iss_ready = 1'b0;

    // Invalid bus ignored; lowest valid matching bus wins; ready operand untouched
    disp(10'h050, 6'd50, 1'b0, 32'h11, 1'b1, 32'h11);
    cdb_drive(0, 1'b0, 6'h11, 32'h7);
    tick(); cdb_clear();
    chk("t5_invalid_bus", 64'(iss_valid), 0);
    cdb_drive(0, 1'b1, 6'h11, 32'h1);
    cdb_drive(1, 1'b0, 6'h11, 32'h2);
    cdb_drive(2, 1'b1, 6'h11, 32'h3);
    tick(); cdb_clear();
    chk("t5_lowest_bus", 64'(iss_opr1), 1);
    chk("t5_ready_kept", 64'(iss_opr2), 64'h11);
    expect_iss(10'h050, 6'd50, 32'h1, 32'h11);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    chk("t5_count_end", 64'(count), 0);

    // Kill overrides dispatch, issue and wakeup
    disp(10'h060, 6'd60, 1'b1, 32'h60, 1'b1, 32'h61);
    disp(10'h061, 6'd61, 1'b0, 32'h3E, 1'b1, 32'h62);
    disp(10'h062, 6'd62, 1'b1, 32'h63, 1'b1, 32'h64);
    disp(10'h063, 6'd63, 1'b0, 32'h3F, 1'b1, 32'h65);
    chk("t6_count_before", 64'(count), 4);
    kill = 1'b1; iss_ready = 1'b1;
    cdb_drive(0, 1'b1, 6'h3E, 32'hEE);
    disp(10'h066, 6'd6, 1'b1, 32'h66, 1'b1, 32'h67);
    kill = 1'b0;
    cdb_clear();
    chk("t6_count",      64'(count), 0);
    chk("t6_iss_valid",  64'(iss_valid), 0);
    chk("t6_disp_ready", 64'(disp_ready), 1);
    chk("t6_iss_op",     64'(iss_op), 0);
    tick();
    chk("t6_nothing_written", 64'(count), 0);
    iss_ready = 1'b0;
    expect_iss(10'h070, 6'd7, 32'h70, 32'h71);
    disp(10'h070, 6'd7, 1'b1, 32'h70, 1'b1, 32'h71);
    chk("t6_after_kill_count", 64'(count), 1);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    chk("t6_after_kill_end", 64'(count), 0);

    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_int_age.md
Name: rs_int_age

Overview:
Parametrised integer reservation station for the out-of-order core. It sits between decode/rename dispatch and the integer ALU. Each entry holds one renamed op. Waiting operands are captured from NUM_CDB common data buses, each bus qualified by its own valid bit. Each cycle the station issues the oldest fully-ready entry under a valid/ready handshake with the execution unit.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
NUM_CDB, 3, number of CDB broadcast ports
TAG_W, 6, physical tag / ROB tag width
DATA_W, 32, operand data width (>= TAG_W)
OP_W, 10, opcode/instruction-type field width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
kill  in  1  flush all entries (branch mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept a dispatch this cycle
disp_op  in  OP_W  instruction type
disp_dest  in  TAG_W  destination tag
disp_rdy1  in  1  src1 holds a value (1) or a tag in low TAG_W bits (0)
disp_src1  in  DATA_W  src1 value/tag
disp_rdy2  in  1  same for src2
disp_src2  in  DATA_W  src2 value/tag
cdb_valid  in  NUM_CDB  per-bus broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  bus i tag at [i*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  bus i data at [i*DATA_W +: DATA_W]
iss_valid  out  1  an entry is offered to the ALU
iss_ready  in  1  ALU accepts this cycle
iss_op  out  OP_W  issued opcode
iss_dest  out  TAG_W  issued destination tag
iss_opr1  out  DATA_W  issued operand 1
iss_opr2  out  DATA_W  issued operand 2
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset and kill share priority: at a clock edge with reset=1 or kill=1, all entries become free and count=0. Both override any dispatch, issue or wakeup in the same cycle.
- Outputs after reset: disp_ready=1, iss_valid=0, iss_op/dest/opr1/opr2=0, count=0.
- disp_ready = (count != DEPTH). It is registered-state based and does not credit a same-cycle issue.
- Dispatch: when disp_valid && disp_ready, write to the lowest-index free entry at the edge.
  - The new entry is the youngest.
  - A dispatch with disp_ready=0 is ignored; the source is responsible for holding it.
- Dispatch bypass: if a dispatching operand has rdy=0 and its tag equals cdb_tag[i] with cdb_valid[i]=1 in the same cycle, store it as ready with cdb_data[i].
- Wakeup: for each busy entry with a waiting operand, compare the operand's low TAG_W bits against every bus where cdb_valid[i]=1. On a match, capture the data and mark the operand ready.
  - If several buses match, the lowest bus index wins.
  - Buses with cdb_valid=0 are never compared.
- Issue eligibility: entry is busy and both operands are ready in registered state. Wakeup therefore enables issue no earlier than the cycle after the broadcast; there is no CDB-to-issue combinational path.
- Selection: among eligible entries, pick the oldest by dispatch order, independent of index. Age tracking survives wrap-around and out-of-order frees, e.g. an age matrix.
- iss_valid=1 when any entry is eligible. iss_* are driven combinationally from the selected entry's registered fields. When iss_valid=0, iss_* are all zero.
- Handshake: on iss_valid && iss_ready, the selected entry is freed at the edge. With iss_ready=0, nothing is freed and the same oldest-eligible entry stays selected. Selection may switch only if an older entry becomes eligible.
- Simultaneous dispatch and issue: both occur. The freed slot is not reusable until the next cycle. count is unchanged.
- count updates by +1 (dispatch only), -1 (issue only) or 0, and never exceeds DEPTH.
- Ready operands are never overwritten by the CDB. Free entries ignore the CDB.

Test Plan:
1. Reset, then dispatch 8 ops with both operands ready and iss_ready=0 -> count=8, disp_ready=0. A 9th disp_valid is ignored and count stays 8.
2. Fill entries 0..3 with waiting ops: tags 5,6,7,8 on src1, src2 ready. Broadcast tag 8 and then tag 6 in later cycles, iss_ready=1 -> the entry waiting on tag 8 issues first. The entry waiting on tag 6 issues the cycle after its own wakeup.
3. Entries at index 2 (older) and index 0 (younger, refilled after a free) both become eligible in the same cycle -> index 2 issues first.
4. Dispatch src1 tag 0x0A with rdy1=0 while cdb_valid=3'b010 and cdb_tag[1]=0x0A, data 0xDEADBEEF -> the entry is eligible next cycle with iss_opr1=0xDEADBEEF.
5. cdb0 and cdb2 both valid with tag 0x11, data 0x1 and 0x3 -> the waiting operand captures 0x1. A bus with matching tag but cdb_valid=0 causes no capture.
6. Four busy entries, kill asserted together with disp_valid and iss_ready -> next cycle count=0, iss_valid=0, disp_ready=1, nothing issued or written.
